// File: rtl/eth_mii_rx_if.sv
// MII receive bundle: PHY-side nibble inputs plus the assembled byte stream
// and frame terminator presented to the downstream byte-to-word packer.
interface eth_mii_rx_if;
  logic [3:0] mii_rxd;
  logic       mii_rxdv;
  logic       mii_rxer;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       rxeop;
  logic       rxerr;

  modport master (
    output mii_rxd, mii_rxdv, mii_rxer,
    input  rxdata, rxvalid, rxeop, rxerr
  );

  modport slave (
    input  mii_rxd, mii_rxdv, mii_rxer,
    output rxdata, rxvalid, rxeop, rxerr
  );
endinterface

// File: rtl/eth_mii_rx.sv
// MII receive front end: strips preamble/SFD, pairs nibbles into bytes and
// emits a byte stream with a separate end-of-frame strobe and error qualifier.
module eth_mii_rx #(
  parameter int MAX_BYTES = 1536
) (
  input logic         clk,
  input logic         rst,
  eth_mii_rx_if.slave bus
);

  typedef enum logic [2:0] {SYNC, IDLE, PRE, LO, HI} state_t;

  localparam logic [11:0] MAX_CNT = 12'(MAX_BYTES);
  localparam logic [3:0]  NIB_PRE = 4'h5;
  localparam logic [3:0]  NIB_SFD = 4'hD;

  state_t      state_reg;
  logic [11:0] count_reg;
  logic        err_reg;
  logic [3:0]  lo_nib_reg;
  logic [7:0]  rxdata_reg;
  logic        rxvalid_reg;
  logic        rxeop_reg;
  logic        rxerr_reg;

  assign bus.rxdata  = rxdata_reg;
  assign bus.rxvalid = rxvalid_reg;
  assign bus.rxeop   = rxeop_reg;
  assign bus.rxerr   = rxerr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= SYNC;
      count_reg   <= '0;
      err_reg     <= 1'b0;
      lo_nib_reg  <= '0;
      rxdata_reg  <= '0;
      rxvalid_reg <= 1'b0;
      rxeop_reg   <= 1'b0;
      rxerr_reg   <= 1'b0;
    end else begin
      rxvalid_reg <= 1'b0;
      rxeop_reg   <= 1'b0;
      rxerr_reg   <= 1'b0;
      case (state_reg)
        // Never join a frame mid-flight: wait for a carrier gap first.
        SYNC: begin
          if (!bus.mii_rxdv) state_reg <= IDLE;
        end
        IDLE, PRE: begin
          if (!bus.mii_rxdv) begin
            state_reg <= IDLE;
          end else if (bus.mii_rxd == NIB_PRE) begin
            state_reg <= PRE;
          end else if (bus.mii_rxd == NIB_SFD) begin
            state_reg <= LO;
            count_reg <= '0;
            err_reg   <= 1'b0;
          end else begin
            state_reg <= SYNC;
          end
        end
        LO: begin
          if (bus.mii_rxdv) begin
            lo_nib_reg <= bus.mii_rxd;
            if (bus.mii_rxer) err_reg <= 1'b1;
            state_reg <= HI;
          end else begin
            if (count_reg != 12'd0) begin
              rxeop_reg <= 1'b1;
              rxerr_reg <= err_reg;
            end
            state_reg <= IDLE;
          end
        end
        HI: begin
          if (bus.mii_rxdv) begin
            // Bytes past the limit are dropped but the frame is marked bad.
            if (count_reg < MAX_CNT) begin
              rxdata_reg  <= {bus.mii_rxd, lo_nib_reg};
              rxvalid_reg <= 1'b1;
              count_reg   <= count_reg + 12'd1;
            end else begin
              err_reg <= 1'b1;
            end
            if (bus.mii_rxer) err_reg <= 1'b1;
            state_reg <= LO;
          end else begin
            err_reg <= 1'b1;
            if (count_reg != 12'd0) begin
              rxeop_reg <= 1'b1;
              rxerr_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mii_rx.sv
// Bench for eth_mii_rx: two instances (full-size and MAX_BYTES=16) share the
// same MII stimulus; expected events are queued per instance and matched on output.
module tb_eth_mii_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  eth_mii_rx_if if_a ();
  eth_mii_rx_if if_b ();

  eth_mii_rx #(.MAX_BYTES(1536)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  eth_mii_rx #(.MAX_BYTES(16))   dut_b (.clk(clk), .rst(rst), .bus(if_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_eop;
    int data;
    bit err;
    int due;
  } ev_t;

  typedef struct {
    int npre;
    bit bad_pre;
    int nbytes;
    int start;
    bit odd;
    int rxer_byte;
    int n_a;
    bit eop_a;
    bit err_a;
    int n_b;
    bit eop_b;
    bit err_b;
  } vec_t;

  ev_t q_a[$];
  ev_t q_b[$];
  int  pass_cnt = 0;
  int  total    = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_ev(input int which, input bit is_eop, input int data, input bit err);
    ev_t ev;
    ev.is_eop = is_eop;
    ev.data   = data;
    ev.err    = err;
    ev.due    = cyc + 1;
    if (which == 0) q_a.push_back(ev);
    else            q_b.push_back(ev);
  endtask

  task automatic mon(input int which, input logic v, input logic [7:0] d,
                     input logic e, input logic er);
    ev_t ev;
    bit  have;
    if (v && e) check($sformatf("dut%0d_rxvalid_rxeop_overlap", which), 1, 0);
    if (!e && er) check($sformatf("dut%0d_rxerr_without_rxeop", which), 1, 0);
    if (v || e) begin
      have = (which == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
      if (!have) begin
        check($sformatf("dut%0d_unexpected_%s", which, v ? "rxvalid" : "rxeop"), 1, 0);
      end else begin
        if (which == 0) ev = q_a.pop_front();
        else            ev = q_b.pop_front();
        check($sformatf("dut%0d_event_is_eop", which), int'(e), int'(ev.is_eop));
        if (ev.is_eop) check($sformatf("dut%0d_rxerr", which), int'(er), int'(ev.err));
        else           check($sformatf("dut%0d_rxdata", which), int'(d), ev.data);
        check($sformatf("dut%0d_latency", which), cyc, ev.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, if_a.rxvalid, if_a.rxdata, if_a.rxeop, if_a.rxerr);
      mon(1, if_b.rxvalid, if_b.rxdata, if_b.rxeop, if_b.rxerr);
    end
  end

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    @(negedge clk);
    if_a.mii_rxdv = dv;
    if_a.mii_rxd  = d;
    if_a.mii_rxer = er;
    if_b.mii_rxdv = dv;
    if_b.mii_rxd  = d;
    if_b.mii_rxer = er;
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0] b;
    for (int p = 0; p < v.npre; p++) drive(1'b1, (v.bad_pre && p == 2) ? 4'h3 : 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < v.nbytes; i++) begin
      b = 8'(v.start + i);
      drive(1'b1, b[3:0], i == v.rxer_byte);
      drive(1'b1, b[7:4], 1'b0);
      if (i < v.n_a) push_ev(0, 1'b0, int'(b), 1'b0);
      if (i < v.n_b) push_ev(1, 1'b0, int'(b), 1'b0);
    end
    if (v.odd) drive(1'b1, 4'hE, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    if (v.eop_a) push_ev(0, 1'b1, 0, v.err_a);
    if (v.eop_b) push_ev(1, 1'b1, 0, v.err_b);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_a_rxdata"},  int'(if_a.rxdata),  0);
    check({tag, "_a_rxvalid"}, int'(if_a.rxvalid), 0);
    check({tag, "_a_rxeop"},   int'(if_a.rxeop),   0);
    check({tag, "_a_rxerr"},   int'(if_a.rxerr),   0);
    check({tag, "_b_rxdata"},  int'(if_b.rxdata),  0);
    check({tag, "_b_rxvalid"}, int'(if_b.rxvalid), 0);
    check({tag, "_b_rxeop"},   int'(if_b.rxeop),   0);
    check({tag, "_b_rxerr"},   int'(if_b.rxerr),   0);
  endtask

  vec_t vecs [11];
  vec_t v12;

  initial begin
    logic [7:0] b;
    //          npre bad nbyt start odd rxer  n_a eop err  n_b eop err
    vecs[0]  = '{7, 1'b0, 64, 'h00, 1'b0, -1, 64, 1'b1, 1'b0, 16, 1'b1, 1'b1};
    vecs[1]  = '{7, 1'b0, 64, 'h00, 1'b1, -1, 64, 1'b1, 1'b1, 16, 1'b1, 1'b1};
    vecs[2]  = '{7, 1'b0, 20, 'h40, 1'b0, 10, 20, 1'b1, 1'b1, 16, 1'b1, 1'b1};
    vecs[3]  = '{7, 1'b0, 20, 'h80, 1'b0, -1, 20, 1'b1, 1'b0, 16, 1'b1, 1'b1};
    vecs[4]  = '{7, 1'b0, 16, 'hA0, 1'b0, -1, 16, 1'b1, 1'b0, 16, 1'b1, 1'b0};
    vecs[5]  = '{7, 1'b0, 17, 'hB0, 1'b0, -1, 17, 1'b1, 1'b0, 16, 1'b1, 1'b1};
    vecs[6]  = '{4, 1'b1,  8, 'hC0, 1'b0, -1,  0, 1'b0, 1'b0,  0, 1'b0, 1'b0};
    vecs[7]  = '{1, 1'b0, 12, 'hD0, 1'b0, -1, 12, 1'b1, 1'b0, 12, 1'b1, 1'b0};
    vecs[8]  = '{7, 1'b0,  0, 'h00, 1'b0, -1,  0, 1'b0, 1'b0,  0, 1'b0, 1'b0};
    vecs[9]  = '{7, 1'b0,  0, 'h00, 1'b1, -1,  0, 1'b0, 1'b0,  0, 1'b0, 1'b0};
    vecs[10] = '{3, 1'b0,  5, 'hF0, 1'b0,  0,  5, 1'b1, 1'b1,  5, 1'b1, 1'b1};
    v12      = '{7, 1'b0, 12, 'h30, 1'b0, -1, 12, 1'b1, 1'b0, 12, 1'b1, 1'b0};

    if_a.mii_rxdv = 1'b0; if_a.mii_rxd = 4'h0; if_a.mii_rxer = 1'b0;
    if_b.mii_rxdv = 1'b0; if_b.mii_rxd = 4'h0; if_b.mii_rxer = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    drive(1'b0, 4'h0, 1'b0);

    for (int k = 0; k < 11; k++) send_frame(vecs[k]);

    // Reset mid-frame: byte 5 just registered when rst hits, frame must vanish.
    for (int p = 0; p < 7; p++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      b = 8'(8'h20 + i);
      drive(1'b1, b[3:0], 1'b0);
      drive(1'b1, b[7:4], 1'b0);
      push_ev(0, 1'b0, int'(b), 1'b0);
      push_ev(1, 1'b0, int'(b), 1'b0);
    end
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h2, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_a_rxvalid", int'(if_a.rxvalid), 1);
    check("pre_rst_a_rxdata",  int'(if_a.rxdata),  'h25);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    drive(1'b1, 4'h6, 1'b0);
    drive(1'b1, 4'h2, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 7; i < 10; i++) begin
      b = 8'(8'h20 + i);
      drive(1'b1, b[3:0], 1'b0);
      drive(1'b1, b[7:4], 1'b0);
    end
    drive(1'b0, 4'h0, 1'b0);
    send_frame(v12);

    repeat (6) drive(1'b0, 4'h0, 1'b0);
    check("dut0_pending_events", q_a.size(), 0);
    check("dut1_pending_events", q_b.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
